computer_system_odata_fifo_pio: RTL and testbench

//  Avalon-MM slave output PIO: CPU writes DATA_W-bit words that are queued in a FIFO and

---
 rtl/computer_system_odata_fifo_pio.sv | 110 +++++++++++
 tb/tb_computer_system_odata_fifo_pio.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/computer_system_odata_fifo_pio.sv
// Avalon-MM output PIO: CPU-written words are queued and presented to the fabric.
// Status/control registers expose fill level, sticky overflow, output enable and flush.
module computer_system_odata_fifo_pio #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;

  // Handshake: a word transfers at a rising edge where out_valid and out_ready are
  // both 1. out_valid never depends on out_ready; out_port is stable while out_valid
  // is high and no transfer has happened.

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, rd_ptr_pop;
  logic [LW-1:0]     level, lvl_pop, level_nxt;
  logic              overflow, enable, enable_nxt;
  logic [DATA_W-1:0] last_wr;
  logic              wr_en, push, pop, full, empty, flush, accept, ovf_set, ovf_clr;
  logic              show_nxt;
  logic [31:0]       status, rd_mux;
  logic              unused_bits;

  assign unused_bits = &{1'b0, writedata};

  assign wr_en   = chipselect & write;
  assign push    = wr_en & (address == 2'd0);
  assign pop     = out_valid & out_ready;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign flush   = wr_en & (address == 2'd2) & writedata[1];
  assign accept  = push & ~full;
  assign ovf_set = push & full;
  assign ovf_clr = wr_en & (address == 2'd1) & writedata[10];

  assign enable_nxt = (wr_en && address == 2'd2) ? writedata[0] : enable;
  assign rd_ptr_pop = rd_ptr + AW'(pop);
  assign lvl_pop    = level - LW'(pop);
  assign level_nxt  = lvl_pop + LW'(accept);
  // A word pushed this edge becomes visible one edge later; the pop takes effect now.
  assign show_nxt   = (lvl_pop != '0) & enable_nxt;

  always_comb begin
    status           = '0;
    status[LW-1:0]   = level;
    status[8]        = empty;
    status[9]        = full;
    status[10]       = overflow;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = 32'(last_wr);
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {31'd0, enable};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= writedata[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_port  <= '0;
      readdata  <= '0;
      overflow  <= 1'b0;
      enable    <= 1'b1;
      last_wr   <= '0;
    end else begin
      readdata <= rd_mux;
      enable   <= enable_nxt;
      if (push) last_wr <= writedata[DATA_W-1:0];
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (flush) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        level     <= '0;
        out_valid <= 1'b0;
      end else begin
        rd_ptr    <= rd_ptr_pop;
        if (accept) wr_ptr <= wr_ptr + AW'(1);
        level     <= level_nxt;
        out_valid <= show_nxt;
        // out_port keeps the last presented word while nothing is valid.
        if (show_nxt) out_port <= mem[rd_ptr_pop];
      end
    end
  end

endmodule

// File: tb/tb_computer_system_odata_fifo_pio.sv
// Directed bench for the output data FIFO PIO: register map, ordering, overflow,
// enable gating, flush and asynchronous reset.
module tb_computer_system_odata_fifo_pio;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_port;
  logic              out_valid;
  logic              out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rv;

  computer_system_odata_fifo_pio #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write      = 1'b1;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  // Scoreboard: every handshake is compared with the head of exp_q.
  task automatic drain(input int n);
    int got = 0;
    int bubbles = 0;
    int cyc = 0;
    bit started = 0;
    out_ready = 1'b1;
    while (got < n && cyc < n + 10) begin
      if (out_valid) begin
        check("drain_data", 32'(out_port), exp_q.pop_front());
        got++;
        started = 1;
      end else if (started) begin
        bubbles++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", got, n);
    check("drain_bubbles", bubbles, 0);
    check("drain_valid_after", 32'(out_valid), 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_port", 32'(out_port), 0);
    check("rst_readdata", readdata, 0);
    reset = 1'b0;
    rd(2'd1, rv); check("rst_status", rv, 32'h100);
    rd(2'd2, rv); check("rst_control", rv, 32'h1);
    rd(2'd0, rv); check("rst_data", rv, 32'h0);

    // Single word, one-cycle presentation latency
    out_ready = 1'b1;
    wr(2'd0, 32'hABCDEF);
    check("single_valid_n", 32'(out_valid), 0);
    tick();
    check("single_valid_n1", 32'(out_valid), 1);
    check("single_port", 32'(out_port), 32'hABCDEF);
    tick();
    check("single_popped", 32'(out_valid), 0);
    check("single_hold", 32'(out_port), 32'hABCDEF);
    out_ready = 1'b0;
    rd(2'd1, rv); check("single_status", rv, 32'h100);
    rd(2'd0, rv); check("single_data_rb", rv, 32'hABCDEF);

    // Overfill: nine pushes into eight slots
    for (int i = 1; i <= 9; i++) wr(2'd0, 32'(i));
    rd(2'd1, rv); check("full_status", rv, 32'h608);
    for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
    drain(8);
    rd(2'd1, rv); check("ovf_sticky", rv, 32'h500);
    wr(2'd1, 32'h400);
    rd(2'd1, rv); check("ovf_clear", rv, 32'h100);

    // Push and pop on the same edge at level 3
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    wr(2'd0, 32'h33);
    check("l3_head", 32'(out_port), 32'h11);
    out_ready = 1'b1;
    wr(2'd0, 32'h44);
    out_ready = 1'b0;
    check("pp_next_head", 32'(out_port), 32'h22);
    rd(2'd1, rv); check("pp_level", rv, 32'h3);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h33);
    exp_q.push_back(32'h44);
    drain(3);

    // Output enable gating at level 5
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h61 + 32'(i));
    check("en_head", 32'(out_port), 32'h61);
    wr(2'd2, 32'h0);
    check("dis_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    tick();
    tick();
    check("dis_still_low", 32'(out_valid), 0);
    rd(2'd1, rv); check("dis_level", rv, 32'h5);
    rd(2'd2, rv); check("dis_control", rv, 32'h0);
    wr(2'd2, 32'h1);
    check("reen_valid", 32'(out_valid), 1);
    check("reen_head", 32'(out_port), 32'h61);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h61 + 32'(i));
    drain(5);

    // Flush after a last write of 0x55
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h81 + 32'(i));
    wr(2'd0, 32'h55);
    wr(2'd2, 32'h3);
    check("flush_valid", 32'(out_valid), 0);
    rd(2'd1, rv); check("flush_status", rv, 32'h100);
    rd(2'd0, rv); check("flush_last_wr", rv, 32'h55);
    rd(2'd2, rv); check("flush_selfclear", rv, 32'h1);
    wr(2'd0, 32'h77);
    tick();
    check("post_flush_head", 32'(out_port), 32'h77);
    exp_q.push_back(32'h77);
    drain(1);

    // Asynchronous reset mid-stream at level 6
    for (int i = 0; i < 6; i++) wr(2'd0, 32'h91 + 32'(i));
    check("pre_rst_valid", 32'(out_valid), 1);
    address = 2'd1;
    tick();
    check("pre_rst_status", readdata, 32'h6);
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_readdata", readdata, 0);
    check("arst_port", 32'(out_port), 0);
    tick();
    reset = 1'b0;
    tick();
    check("arst_status", readdata, 32'h100);
    check("arst_valid_after", 32'(out_valid), 0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
